irq_trap_sequencer: RTL and testbench
=====================================

IRQ_TRAP_SEQUENCER -- requirements
Module: irq_trap_sequencer

Interface
REQ-001 Parameter NUM_SRC, default 4, number of level-sensitive interrupt sources (1..16).
REQ-002 Parameter CAUSE_BASE, default 16, mcause exception code assigned to source 0.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 irq_src  input  NUM_SRC  level interrupt requests.
REQ-006 irq_en  input  NUM_SRC  per-source enables (mie image).
REQ-007 mie_global  input  1  global enable (mstatus.MIE image).
REQ-008 mtvec  input  32  trap vector; [1:0] mode, [31:2] base.
REQ-009 pipe_pc  input  32  PC of oldest uncommitted instruction.
REQ-010 pipe_idle  input  1  pipeline drained, no in-flight writeback.
REQ-011 mret  input  1  one-cycle trap-return pulse from decode.
REQ-012 mepc_in  input  32  current mepc CSR value.
REQ-013 flush  output  1  stall fetch, squash younger instructions.
REQ-014 save_valid  output  1  one-cycle pulse: CSR unit writes mepc/mcause.
REQ-015 save_pc  output  32  value for mepc.
REQ-016 save_cause  output  32  value for mcause.
REQ-017 redirect_valid  output  1  one-cycle pulse: load redirect_pc into PC.
REQ-018 redirect_pc  output  32  new fetch address.
REQ-019 busy  output  1  handler active; further interrupts masked.
REQ-020 irq_count  output  16  number of interrupts taken, wraps 0xFFFF->0x0000.

Function
REQ-021 FSM states SHALL be IDLE, DRAIN, SAVE, VECTOR, HANDLER, RETURN.
REQ-022 IDLE: if mie_global & |(irq_src & irq_en), latch winning index into cause_q, go to DRAIN; else stay.
REQ-023 Winner SHALL be the lowest-numbered source with irq_src & irq_en set (fixed priority).
REQ-024 DRAIN: flush=1; go to SAVE in the cycle after pipe_idle is sampled high; wait indefinitely otherwise.
REQ-025 Once DRAIN is entered the trap SHALL complete even if irq_src, irq_en or mie_global deassert.
REQ-026 SAVE: flush=1, save_valid=1 for exactly one cycle, save_pc=pipe_pc, save_cause={1'b1, 31-bit CAUSE_BASE+cause_q}; go to VECTOR.
REQ-027 VECTOR: flush=1, redirect_valid=1 for one cycle; go to HANDLER; irq_count increments on this cycle.
REQ-028 redirect_pc in VECTOR: mode 00 -> {base,2'b00}; mode 01 -> {base,2'b00} + (code<<2) using the mcause code (low bits of save_cause); modes 10/11 treated as 00.
REQ-029 HANDLER: busy=1; irq_src ignored; on mret go to RETURN.
REQ-030 RETURN: redirect_valid=1, redirect_pc=mepc_in, busy=1; go to IDLE.
REQ-031 mret outside HANDLER SHALL be ignored (no state change, no redirect).
REQ-032 Minimum latency: irq sampled at edge N (pipe_idle high) -> save_valid at N+2, redirect_valid at N+3.
REQ-033 Outputs save_*/redirect_pc SHALL be 0 when their valid is low.
REQ-034 Interrupt still pending on return to IDLE SHALL be taken on the next cycle (back-to-back allowed).

Reset
REQ-035 reset SHALL asynchronously force state IDLE, cause_q=0, irq_count=0, and all outputs 0.
REQ-036 Reset mid-trap SHALL abandon the trap; no save_valid or redirect_valid pulse SHALL follow.

Structure
REQ-037 Shared package SHALL hold the state enum, MTVEC_DIRECT/MTVEC_VECTORED mode constants and the mcause interrupt-bit constant.
REQ-038 Fixed-priority selection SHALL be a sub-module irq_prio_encoder (request vector in, valid + index out).

Verification
REQ-039 irq_src=4'b0100, irq_en=4'hF, mie_global=1, pipe_idle=1, mtvec=0x100 -> save_cause=0x80000012, redirect_pc=0x100 three cycles after sampling.
REQ-040 Same with mtvec=0x101 -> redirect_pc=0x148.
REQ-041 irq_src=4'b1010 simultaneously -> source 1 wins, save_cause=0x80000011; source 3 taken after mret return.
REQ-042 pipe_idle low 5 cycles in DRAIN, irq_src dropped meanwhile -> flush held 5+ cycles, trap still completes with latched cause.
REQ-043 mret in IDLE ignored; mret in HANDLER with mepc_in=0x2000 -> redirect_pc=0x2000 next cycle, busy falls after.
REQ-044 reset asserted in SAVE -> all outputs 0 immediately, irq_count=0, no redirect pulse after release.

Source files
------------

// File: rtl/irq_trap_sequencer_pkg.sv
// Shared definitions for the interrupt trap sequencer: FSM state encodings,
// mtvec mode constants, the mcause interrupt bit and the trap-vector helper.
// No ports; imported by the interface, sub-module and top.
package irq_trap_sequencer_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_DRAIN   = 3'd1;
  localparam state_t ST_SAVE    = 3'd2;
  localparam state_t ST_VECTOR  = 3'd3;
  localparam state_t ST_HANDLER = 3'd4;
  localparam state_t ST_RETURN  = 3'd5;

  localparam logic [1:0]  MTVEC_DIRECT   = 2'b00;
  localparam logic [1:0]  MTVEC_VECTORED = 2'b01;

  localparam logic [31:0] MCAUSE_INTR    = 32'h8000_0000;

  // Handler entry address. Only the low 30 code bits can reach the result
  // after the <<2, so that is all the caller passes. Reserved modes fall
  // back to direct.
  function automatic logic [31:0] trap_vector(input logic [31:0] mtvec,
                                              input logic [29:0] code);
    logic [31:0] base;
    base = {mtvec[31:2], 2'b00};
    case (mtvec[1:0])
      MTVEC_DIRECT:   trap_vector = base;
      MTVEC_VECTORED: trap_vector = base + {code, 2'b00};
      default:        trap_vector = base;
    endcase
  endfunction

endpackage

// File: rtl/irq_trap_sequencer_if.sv
// Core-side bundle of the trap sequencer: interrupt inputs, pipeline status,
// CSR images in; flush/save/redirect/busy/count out.
// slave = sequencer view, master = core/environment view.
interface irq_trap_sequencer_if #(
  parameter int NUM_SRC = 4
);
  logic [NUM_SRC-1:0] irq_src;
  logic [NUM_SRC-1:0] irq_en;
  logic               mie_global;
  logic [31:0]        mtvec;
  logic [31:0]        pipe_pc;
  logic               pipe_idle;
  logic               mret;
  logic [31:0]        mepc_in;
  logic               flush;
  logic               save_valid;
  logic [31:0]        save_pc;
  logic [31:0]        save_cause;
  logic               redirect_valid;
  logic [31:0]        redirect_pc;
  logic               busy;
  logic [15:0]        irq_count;

  modport slave (
    input  irq_src, irq_en, mie_global, mtvec, pipe_pc, pipe_idle, mret, mepc_in,
    output flush, save_valid, save_pc, save_cause, redirect_valid, redirect_pc,
           busy, irq_count
  );

  modport master (
    output irq_src, irq_en, mie_global, mtvec, pipe_pc, pipe_idle, mret, mepc_in,
    input  flush, save_valid, save_pc, save_cause, redirect_valid, redirect_pc,
           busy, irq_count
  );
endinterface

// File: rtl/irq_trap_sequencer_prio_encoder.sv
// Fixed-priority encoder: lowest-numbered set request wins.
// Latency: combinational. Backpressure: none.
// Ports: req_i request vector; vld_o any request set; idx_o winning index.
module irq_prio_encoder #(
  parameter int N = 4
) (
  input  logic [N-1:0] req_i,
  output logic         vld_o,
  output logic [3:0]   idx_o
);

  // Scan high to low so the last (lowest) set bit overwrites earlier hits.
  always_comb begin
    vld_o = |req_i;
    idx_o = 4'd0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[i]) idx_o = 4'(i);
    end
  end

endmodule

// File: rtl/irq_trap_sequencer.sv
// Interrupt trap sequencer: drain pipeline, save mepc/mcause, vector, return on mret.
// Latency: irq sampled at edge N with pipe idle -> save pulse N+2, redirect N+3.
// Backpressure: DRAIN waits indefinitely for pipe_idle; HANDLER waits for mret.
// Ports: clk, reset (async, active high), bus (slave modport, see interface).
module irq_trap_sequencer
  import irq_trap_sequencer_pkg::*;
#(
  parameter int NUM_SRC    = 4,
  parameter int CAUSE_BASE = 16
) (
  input  logic clk,
  input  logic reset,
  irq_trap_sequencer_if.slave bus
);

  state_t      state_q, state_d;
  logic [3:0]  cause_q, cause_d;
  logic [15:0] count_q;

  logic [NUM_SRC-1:0] req;
  logic               win_vld;
  logic [3:0]         win_idx;
  logic [30:0]        cause_code;
  logic [31:0]        cause_full;

  assign req = bus.irq_src & bus.irq_en;

  irq_prio_encoder #(.N(NUM_SRC)) u_prio (
    .req_i (req),
    .vld_o (win_vld),
    .idx_o (win_idx)
  );

  assign cause_code = 31'(CAUSE_BASE) + {27'd0, cause_q};
  assign cause_full = MCAUSE_INTR | {1'b0, cause_code};

  // Only IDLE looks at the requests; once a trap starts it runs to completion.
  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.mie_global && win_vld) begin
          cause_d = win_idx;
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN:   if (bus.pipe_idle) state_d = ST_SAVE;
      ST_SAVE:    state_d = ST_VECTOR;
      ST_VECTOR:  state_d = ST_HANDLER;
      ST_HANDLER: if (bus.mret) state_d = ST_RETURN;
      ST_RETURN:  state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Outputs decode straight from state so reset clears them immediately.
  always_comb begin
    bus.flush          = 1'b0;
    bus.save_valid     = 1'b0;
    bus.save_pc        = 32'd0;
    bus.save_cause     = 32'd0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'd0;
    bus.busy           = 1'b0;
    case (state_q)
      ST_DRAIN: bus.flush = 1'b1;
      ST_SAVE: begin
        bus.flush      = 1'b1;
        bus.save_valid = 1'b1;
        bus.save_pc    = bus.pipe_pc;
        bus.save_cause = cause_full;
      end
      ST_VECTOR: begin
        bus.flush          = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = trap_vector(bus.mtvec, cause_full[29:0]);
      end
      ST_HANDLER: bus.busy = 1'b1;
      ST_RETURN: begin
        bus.busy           = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = bus.mepc_in;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cause_q <= 4'd0;
      count_q <= 16'd0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      if (state_q == ST_VECTOR) count_q <= count_q + 16'd1;
    end
  end

  assign bus.irq_count = count_q;

endmodule

// File: tb/tb_irq_trap_sequencer.sv
module tb_irq_trap_sequencer;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  irq_trap_sequencer_if #(.NUM_SRC(4)) bus ();

  irq_trap_sequencer #(.NUM_SRC(4), .CAUSE_BASE(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic        is_redir;
    logic [31:0] pc;
    logic [31:0] cause;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  localparam logic [31:0] PC0 = 32'h0000_0A00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
    end
  endtask

  task automatic push_save(input logic [31:0] pc, input logic [31:0] cause);
    exp_t e;
    e.is_redir = 1'b0; e.pc = pc; e.cause = cause;
    sb_q.push_back(e);
  endtask

  task automatic push_redir(input logic [31:0] pc);
    exp_t e;
    e.is_redir = 1'b1; e.pc = pc; e.cause = 32'd0;
    sb_q.push_back(e);
  endtask

  // Monitor: pops one expectation per save/redirect pulse; idle payloads must be zero.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.save_valid === 1'b1) begin
        if (sb_q.size() == 0) check("unexpected_save", 32'd1, 32'd0);
        else begin
          e = sb_q.pop_front();
          check("save_kind", {31'd0, e.is_redir}, 32'd0);
          check("save_pc", bus.save_pc, e.pc);
          check("save_cause", bus.save_cause, e.cause);
        end
      end else begin
        check("save_idle_zero", bus.save_pc | bus.save_cause, 32'd0);
      end
      if (bus.redirect_valid === 1'b1) begin
        if (sb_q.size() == 0) check("unexpected_redirect", 32'd1, 32'd0);
        else begin
          e = sb_q.pop_front();
          check("redir_kind", {31'd0, e.is_redir}, 32'd1);
          check("redirect_pc", bus.redirect_pc, e.pc);
        end
      end else begin
        check("redir_idle_zero", bus.redirect_pc, 32'd0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_busy(input logic v, input string name);
    int k;
    k = 0;
    while (bus.busy !== v && k < 100) begin
      @(negedge clk);
      k++;
    end
    check(name, {31'd0, bus.busy}, {31'd0, v});
  endtask

  task automatic do_return(input logic [31:0] mepc);
    wait_busy(1'b1, "busy_before_mret");
    tick();
    bus.mepc_in = mepc;
    bus.mret    = 1'b1;
    push_redir(mepc);
    tick();
    bus.mret = 1'b0;
    @(negedge clk);
    check("ret_busy", {31'd0, bus.busy}, 32'd1);
    check("ret_redir_vld", {31'd0, bus.redirect_valid}, 32'd1);
    @(negedge clk);
    check("ret_busy_fall", {31'd0, bus.busy}, 32'd0);
  endtask

  initial begin
    reset          = 1'b1;
    bus.irq_src    = 4'h0;
    bus.irq_en     = 4'hF;
    bus.mie_global = 1'b1;
    bus.mtvec      = 32'h100;
    bus.pipe_pc    = PC0;
    bus.pipe_idle  = 1'b1;
    bus.mret       = 1'b0;
    bus.mepc_in    = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_flush", {31'd0, bus.flush}, 32'd0);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_count", {16'd0, bus.irq_count}, 32'd0);
    reset = 1'b0;

    // mret while IDLE must do nothing
    tick();
    bus.mepc_in = 32'h2000;
    bus.mret    = 1'b1;
    tick();
    bus.mret = 1'b0;
    @(negedge clk);
    check("idle_mret_busy", {31'd0, bus.busy}, 32'd0);
    check("idle_mret_redir", {31'd0, bus.redirect_valid}, 32'd0);
    check("idle_mret_flush", {31'd0, bus.flush}, 32'd0);

    // Source 2, direct mode, exact latency
    tick();
    push_save(PC0, 32'h8000_0012);
    push_redir(32'h100);
    bus.irq_src = 4'b0100;
    @(posedge clk);
    #1 bus.irq_src = 4'b0000;
    @(negedge clk);
    check("t1_drain_flush", {31'd0, bus.flush}, 32'd1);
    check("t1_drain_nosave", {31'd0, bus.save_valid}, 32'd0);
    @(negedge clk);
    check("t1_save_n2", {31'd0, bus.save_valid}, 32'd1);
    @(negedge clk);
    check("t1_redir_n3", {31'd0, bus.redirect_valid}, 32'd1);
    @(negedge clk);
    check("t1_busy", {31'd0, bus.busy}, 32'd1);
    check("t1_count", {16'd0, bus.irq_count}, 32'd1);
    do_return(32'h2000);

    // Source 2, vectored mode: 0x100 + 18*4
    tick();
    bus.mtvec = 32'h101;
    push_save(PC0, 32'h8000_0012);
    push_redir(32'h148);
    bus.irq_src = 4'b0100;
    @(posedge clk);
    #1 bus.irq_src = 4'b0000;
    wait_busy(1'b1, "t2_busy");
    check("t2_count", {16'd0, bus.irq_count}, 32'd2);
    do_return(32'h2000);

    // Sources 1 and 3 together: 1 first, 3 back-to-back after return
    tick();
    bus.mtvec = 32'h100;
    push_save(PC0, 32'h8000_0011);
    push_redir(32'h100);
    bus.irq_src = 4'b1010;
    wait_busy(1'b1, "t3_busy_a");
    bus.irq_src = 4'b1000;
    do_return(32'h3000);
    push_save(PC0, 32'h8000_0013);
    push_redir(32'h100);
    @(posedge clk);
    #1;
    check("t3_b2b_flush", {31'd0, bus.flush}, 32'd1);
    bus.irq_src = 4'b0000;
    wait_busy(1'b1, "t3_busy_b");
    check("t3_count", {16'd0, bus.irq_count}, 32'd4);
    do_return(32'h3004);

    // Long drain, request and enables dropped after entry
    tick();
    bus.mtvec     = 32'h101;
    bus.pipe_idle = 1'b0;
    push_save(PC0, 32'h8000_0010);
    push_redir(32'h140);
    bus.irq_src = 4'b0001;
    @(posedge clk);
    #1;
    bus.irq_src    = 4'b0000;
    bus.irq_en     = 4'h0;
    bus.mie_global = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t4_flush_held", {31'd0, bus.flush}, 32'd1);
      check("t4_no_save", {31'd0, bus.save_valid}, 32'd0);
    end
    tick();
    bus.pipe_idle = 1'b1;
    wait_busy(1'b1, "t4_busy");
    check("t4_count", {16'd0, bus.irq_count}, 32'd5);
    do_return(32'h2000);
    bus.irq_en     = 4'hF;
    bus.mie_global = 1'b1;

    // Reset while in SAVE abandons the trap
    tick();
    push_save(PC0, 32'h8000_0011);
    bus.irq_src = 4'b0010;
    @(posedge clk);
    #1 bus.irq_src = 4'b0000;
    @(negedge clk);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("rst_save_vld", {31'd0, bus.save_valid}, 32'd0);
    check("rst_save_cause", bus.save_cause, 32'd0);
    check("rst_mid_flush", {31'd0, bus.flush}, 32'd0);
    check("rst_mid_redir", {31'd0, bus.redirect_valid}, 32'd0);
    check("rst_mid_count", {16'd0, bus.irq_count}, 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (6) @(negedge clk);
    check("post_rst_busy", {31'd0, bus.busy}, 32'd0);
    check("post_rst_count", {16'd0, bus.irq_count}, 32'd0);

    check("sb_empty", sb_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
